stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter DW, 8, data word width; SHALL match the 8-bit RAM word.
REQ-002 Parameter AW, 5, RAM address width; depth is 2**AW = 32 words.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 push  input  1  request to push din; sampled only in IDLE.
REQ-006 pop  input  1  request to pop the top word; sampled only in IDLE.
REQ-007 din  input  DW  push data; captured in the cycle push is accepted.
REQ-008 dout  output  DW  popped or peeked word; registered.
REQ-009 dout_valid  output  1  one-cycle strobe qualifying dout.
REQ-010 busy  output  1  high while a RAM access is in progress.
REQ-011 full  output  1  count == 32.
REQ-012 empty  output  1  count == 0.
REQ-013 err  output  1  one-cycle strobe on a rejected request.
REQ-014 ram_adr  output  AW  RAM address.
REQ-015 ram_rws  output  1  RAM read/write select (1 = write, 0 = read).
REQ-016 ram_cs  output  1  RAM chip select.
REQ-017 ram_in  output  DW  write data to RAM.
REQ-018 ram_out  input  DW  read data from RAM; combinational, valid while ram_cs=1 and ram_rws=0.

Function
REQ-019 FSM states SHALL be IDLE, WR and RD, plus PK when STACK_PEEK_EN is defined; reset state is IDLE.
REQ-020 count SHALL be 6 bits, range 0..32, and SHALL be the only stack pointer; the top word is at address count-1.
REQ-021 IDLE with push=1, pop=0 and not full -> WR; din is latched into ram_in; ram_adr=count[4:0].
REQ-022 WR SHALL last exactly one cycle with ram_cs=1 and ram_rws=1; count increments at its end; next state is IDLE.
REQ-023 IDLE with pop=1, push=0 and not empty -> RD; ram_adr=count-1.
REQ-024 RD SHALL last exactly one cycle with ram_cs=1 and ram_rws=0; ram_out is registered into dout at its end; count decrements; next state is IDLE.
REQ-025 dout_valid SHALL be high for exactly the one cycle after RD, so pop accepted in cycle N gives dout_valid in cycle N+2.
REQ-026 Outside WR, RD and PK, ram_cs SHALL be 0 and ram_rws SHALL be 0.
REQ-027 busy SHALL be high in WR, RD and PK; push and pop SHALL be ignored (not queued, no err) while busy.
REQ-028 Push while full, pop while empty, or push and pop together in IDLE -> err=1 for one cycle; no RAM access; count unchanged.
REQ-029 full and empty SHALL be decoded combinationally from registered count, so they reflect the new count in the cycle after WR or RD.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, count=0, dout=0, dout_valid=0, err=0, ram_cs=0, ram_rws=0, ram_adr=0 and ram_in=0, so empty=1 and full=0.
REQ-031 rst asserted during WR or RD SHALL abort the access (ram_cs drops asynchronously) with no count change; the controller SHALL NOT clear RAM contents.

Configuration
REQ-032 Macro STACK_PEEK_EN defined: adds input peek (1 bit). IDLE with peek=1, not empty, push=0 and pop=0 -> PK, a one-cycle read of count-1; dout is updated and dout_valid pulses as for pop; count is unchanged. Peek while empty -> err. Peek together with push or pop -> err.
REQ-033 Macro STACK_PEEK_EN undefined: no peek port and no PK state; behaviour is otherwise identical.

Structure
REQ-034 Package stack_pkg SHALL hold DW, AW, DEPTH=32 and the FSM state encoding.
REQ-035 One sub-module, stack_ptr (6-bit up/down counter with full/empty decode), SHALL be instantiated. Address and RAM-control generation SHALL stay in stack_ctrl.

Verification
REQ-036 Reset, then push 8'hA5: ram_cs=1 and ram_rws=1 with ram_adr=0 and ram_in=A5 for one cycle; then count=1 and empty=0.
REQ-037 Push 8'h11, 8'h22, 8'h33, then pop three times: dout sequence 33, 22, 11, each with a dout_valid pulse two cycles after acceptance; then empty=1.
REQ-038 Push 32 words: full=1, and the 33rd push gives err pulse with no ram_cs. Pop on empty after reset gives err pulse with no ram_cs.
REQ-039 push=pop=1 in IDLE -> err pulse with count unchanged. push held high during WR -> exactly one write.
REQ-040 Assert rst mid-RD with count=5: ram_cs=0 at once; after release empty=1, dout=0 and dout_valid=0. With STACK_PEEK_EN, peek after pushing 8'h7E -> dout=7E and count stays 1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared widths and FSM encoding for the LIFO stack controller.
// STACK_PEEK_EN adds the PK (peek) state.
package stack_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
`ifdef STACK_PEEK_EN
        ,
        PK   = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer: up/down word counter with full/empty decode.
module stack_ptr #(
    parameter int unsigned AW = stack_pkg::AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        dec,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PW = AW + 1;

    logic [AW:0] count_q;
    logic [AW:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + PW'(1);
        end else if (dec) begin
            count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == PW'(2 ** AW));
    assign empty = (count_q == '0);

endmodule

// File: rtl/stack_ctrl.sv
// LIFO stack controller in front of a single-port RAM (one cycle per access).
// Define STACK_PEEK_EN to add the peek port and PK state.
module stack_ctrl #(
    parameter int unsigned DW = stack_pkg::DW,
    parameter int unsigned AW = stack_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
`ifdef STACK_PEEK_EN
    input  logic          peek,
`endif
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic          err,
    output logic [AW-1:0] ram_adr,
    output logic          ram_rws,
    output logic          ram_cs,
    output logic [DW-1:0] ram_in,
    input  logic [DW-1:0] ram_out
);

    import stack_pkg::*;

    localparam int unsigned PW = AW + 1;

    state_e        state_q, state_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [AW-1:0] ram_adr_q, ram_adr_d;
    logic          ram_rws_q, ram_rws_d;
    logic          ram_cs_q, ram_cs_d;
    logic [DW-1:0] ram_in_q, ram_in_d;

    logic [AW:0]   count;
    logic          ptr_inc_c;
    logic          ptr_dec_c;
    logic          peek_c;

`ifdef STACK_PEEK_EN
    assign peek_c = peek;
`else
    assign peek_c = 1'b0;
`endif

    // Pointer moves only at the end of a completed access.
    assign ptr_inc_c = (state_q == WR);
    assign ptr_dec_c = (state_q == RD);

    stack_ptr #(.AW(AW)) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (ptr_inc_c),
        .dec   (ptr_dec_c),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        busy_d       = 1'b0;
        err_d        = 1'b0;
        ram_adr_d    = ram_adr_q;
        ram_rws_d    = 1'b0;
        ram_cs_d     = 1'b0;
        ram_in_d     = ram_in_q;

        case (state_q)
            IDLE: begin
                if (push && !pop && !peek_c && !full) begin
                    state_d   = WR;
                    busy_d    = 1'b1;
                    ram_cs_d  = 1'b1;
                    ram_rws_d = 1'b1;
                    ram_adr_d = count[AW-1:0];
                    ram_in_d  = din;
                end else if (pop && !push && !peek_c && !empty) begin
                    state_d   = RD;
                    busy_d    = 1'b1;
                    ram_cs_d  = 1'b1;
                    ram_adr_d = AW'(count - PW'(1));
`ifdef STACK_PEEK_EN
                end else if (peek_c && !push && !pop && !empty) begin
                    state_d   = PK;
                    busy_d    = 1'b1;
                    ram_cs_d  = 1'b1;
                    ram_adr_d = AW'(count - PW'(1));
`endif
                end else if (push || pop || peek_c) begin
                    err_d = 1'b1;
                end
            end
            WR: begin
                state_d = IDLE;
            end
`ifdef STACK_PEEK_EN
            RD, PK: begin
`else
            RD: begin
`endif
                state_d      = IDLE;
                dout_d       = ram_out;
                dout_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            ram_adr_q    <= '0;
            ram_rws_q    <= 1'b0;
            ram_cs_q     <= 1'b0;
            ram_in_q     <= '0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            ram_adr_q    <= ram_adr_d;
            ram_rws_q    <= ram_rws_d;
            ram_cs_q     <= ram_cs_d;
            ram_in_q     <= ram_in_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign ram_adr    = ram_adr_q;
    assign ram_rws    = ram_rws_q;
    assign ram_cs     = ram_cs_q;
    assign ram_in     = ram_in_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl with a behavioural RAM and a dout scoreboard.
// Define STACK_PEEK_EN to also exercise peek.
module tb_stack_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
`ifdef STACK_PEEK_EN
    logic          peek = 1'b0;
`endif
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          full;
    logic          empty;
    logic          err;
    logic [AW-1:0] ram_adr;
    logic          ram_rws;
    logic          ram_cs;
    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [$];
    int            checks = 0;
    int            errors = 0;
    int            writes = 0;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
`ifdef STACK_PEEK_EN
        .peek       (peek),
`endif
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .full       (full),
        .empty      (empty),
        .err        (err),
        .ram_adr    (ram_adr),
        .ram_rws    (ram_rws),
        .ram_cs     (ram_cs),
        .ram_in     (ram_in),
        .ram_out    (ram_out)
    );

    assign ram_out = mem[ram_adr];

    always @(posedge clk) begin
        if (ram_cs && ram_rws) begin
            mem[ram_adr] <= ram_in;
            writes <= writes + 1;
        end
    end

    // Scoreboard: every dout_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dout_unexpected: got %h with nothing expected", dout);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL dout_value: got %h expected %h", dout, e);
                end
            end
        end
    end

    task automatic apply_reset();
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
`ifdef STACK_PEEK_EN
        peek = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model.delete();
        exp_q.delete();
    endtask

    task automatic do_push(input logic [DW-1:0] d);
        logic [AW-1:0] a;
        a = AW'(model.size());
        @(negedge clk);
        push = 1'b1;
        din  = d;
        @(negedge clk);
        push = 1'b0;
        checks++;
        if (ram_cs !== 1'b1 || ram_rws !== 1'b1 || ram_adr !== a || ram_in !== d || busy !== 1'b1) begin
            errors++;
            $display("FAIL push_access: cs=%b rws=%b adr=%0d in=%h busy=%b expected 1 1 %0d %h 1",
                     ram_cs, ram_rws, ram_adr, ram_in, busy, a, d);
        end
        model.push_back(d);
        @(negedge clk);
        checks++;
        if (dut.u_ptr.count_q !== 6'(model.size()) || ram_cs !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL push_count: count=%0d cs=%b empty=%b expected %0d 0 0",
                     dut.u_ptr.count_q, ram_cs, empty, model.size());
        end
    endtask

    task automatic do_pop();
        logic [AW-1:0] a;
        a = AW'(model.size() - 1);
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        checks++;
        if (ram_cs !== 1'b1 || ram_rws !== 1'b0 || ram_adr !== a || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_access: cs=%b rws=%b adr=%0d dv=%b expected 1 0 %0d 0",
                     ram_cs, ram_rws, ram_adr, dout_valid, a);
        end
        exp_q.push_back(model.pop_back());
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || dut.u_ptr.count_q !== 6'(model.size())) begin
            errors++;
            $display("FAIL pop_valid: dv=%b count=%0d expected 1 %0d",
                     dout_valid, dut.u_ptr.count_q, model.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00 || dout_valid !== 1'b0 ||
            err !== 1'b0 || ram_cs !== 1'b0 || ram_rws !== 1'b0 || ram_adr !== 5'd0 ||
            ram_in !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: empty=%b full=%b dout=%h dv=%b err=%b cs=%b rws=%b adr=%0d in=%h busy=%b",
                     empty, full, dout, dout_valid, err, ram_cs, ram_rws, ram_adr, ram_in, busy);
        end
        apply_reset();
    endtask

    task automatic test_push_single();
        do_push(8'hA5);
        do_pop();
    endtask

    task automatic test_lifo();
        do_push(8'h11);
        do_push(8'h22);
        do_push(8'h33);
        do_pop();
        do_pop();
        do_pop();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL lifo_empty: empty=%b expected 1", empty);
        end
    endtask

    task automatic test_pop_empty();
        apply_reset();
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        checks++;
        if (err !== 1'b1 || ram_cs !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty_err: err=%b cs=%b busy=%b expected 1 0 0", err, ram_cs, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || dut.u_ptr.count_q !== 6'd0) begin
            errors++;
            $display("FAIL pop_empty_after: err=%b count=%0d expected 0 0", err, dut.u_ptr.count_q);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 32; i++) begin
            do_push(DW'($urandom_range(0, 255)));
        end
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flag: full=%b empty=%b expected 1 0", full, empty);
        end
        @(negedge clk);
        push = 1'b1;
        din  = 8'hEE;
        @(negedge clk);
        push = 1'b0;
        checks++;
        if (err !== 1'b1 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL push_full_err: err=%b cs=%b expected 1 0", err, ram_cs);
        end
        @(negedge clk);
        checks++;
        if (dut.u_ptr.count_q !== 6'd32 || err !== 1'b0) begin
            errors++;
            $display("FAIL push_full_count: count=%0d err=%b expected 32 0", dut.u_ptr.count_q, err);
        end
        for (int i = 0; i < 32; i++) begin
            do_pop();
        end
    endtask

    task automatic test_push_pop_together();
        do_push(8'h3C);
        @(negedge clk);
        push = 1'b1;
        pop  = 1'b1;
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        checks++;
        if (err !== 1'b1 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL both_err: err=%b cs=%b expected 1 0", err, ram_cs);
        end
        @(negedge clk);
        checks++;
        if (dut.u_ptr.count_q !== 6'd1) begin
            errors++;
            $display("FAIL both_count: count=%0d expected 1", dut.u_ptr.count_q);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = writes;
        @(negedge clk);
        push = 1'b1;
        din  = 8'h5A;
        repeat (2) @(negedge clk);
        push = 1'b0;
        model.push_back(8'h5A);
        @(negedge clk);
        checks++;
        if (writes - w0 != 1 || dut.u_ptr.count_q !== 6'(model.size())) begin
            errors++;
            $display("FAIL held_push: writes=%0d count=%0d expected 1 %0d",
                     writes - w0, dut.u_ptr.count_q, model.size());
        end
        do_pop();
        do_pop();
    endtask

    task automatic test_reset_mid_rd();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_push(DW'(8'h40 + i));
        end
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (ram_cs !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rd_cs: cs=%b busy=%b expected 0 0", ram_cs, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        repeat (2) @(negedge clk);
        checks++;
        if (empty !== 1'b1 || dout !== 8'h00 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rd_after: empty=%b dout=%h dv=%b expected 1 00 0",
                     empty, dout, dout_valid);
        end
    endtask

`ifdef STACK_PEEK_EN
    task automatic test_peek();
        apply_reset();
        do_push(8'h7E);
        @(negedge clk);
        peek = 1'b1;
        @(negedge clk);
        peek = 1'b0;
        checks++;
        if (ram_cs !== 1'b1 || ram_rws !== 1'b0 || ram_adr !== 5'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL peek_access: cs=%b rws=%b adr=%0d busy=%b expected 1 0 0 1",
                     ram_cs, ram_rws, ram_adr, busy);
        end
        exp_q.push_back(8'h7E);
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || dut.u_ptr.count_q !== 6'd1) begin
            errors++;
            $display("FAIL peek_count: dv=%b count=%0d expected 1 1", dout_valid, dut.u_ptr.count_q);
        end
        @(negedge clk);
        peek = 1'b1;
        push = 1'b1;
        @(negedge clk);
        peek = 1'b0;
        push = 1'b0;
        checks++;
        if (err !== 1'b1 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL peek_push_err: err=%b cs=%b expected 1 0", err, ram_cs);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_push_single();
        test_lifo();
        test_pop_empty();
        test_full();
        test_push_pop_together();
        test_back_to_back();
        test_reset_mid_rd();
`ifdef STACK_PEEK_EN
        test_peek();
`endif
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words never returned, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
